sram_uart_bridge: RTL



---
 rtl/sram_uart_bridge_pkg.sv | 18 +
 rtl/sram_uart_bridge_uart_mmio_regs.sv | 74 +++++++
 rtl/sram_uart_bridge.sv | 117 +++++++++++
 3 files changed

// File: rtl/sram_uart_bridge_pkg.sv
// Shared definitions for the SRAM/UART memory-side responder.
//   - FSM state encoding of the SRAM access sequencer
//   - default addresses of the memory-mapped UART registers
//   - bit positions inside the UART status word
package sram_uart_bridge_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    localparam logic [31:0] DEF_UART_DATA_ADDR = 32'hBFD0_03F8;
    localparam logic [31:0] DEF_UART_STAT_ADDR = 32'hBFD0_03FC;

    localparam int STAT_TX_READY = 0;
    localparam int STAT_RX_FULL  = 1;
    localparam int STAT_OVERRUN  = 2;

endpackage

// File: rtl/sram_uart_bridge_uart_mmio_regs.sv
// uart_mmio_regs: memory-mapped UART register file.
//   clk, rst          clock, synchronous active-high reset
//   rd_data_sel       data register read this cycle (returns rx_buf, clears rx_full)
//   rd_stat_sel       status register read this cycle (clears overrun)
//   wr_data_sel       data register write this cycle (launches TX if idle)
//   wr_byte           byte to transmit
//   uart_tx_*         transmitter launch interface
//   uart_rx_*         receiver byte interface
//   rd_data           read data for the selected register, 0 when none selected
module uart_mmio_regs
    import sram_uart_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_data_sel,
    input  logic        rd_stat_sel,
    input  logic        wr_data_sel,
    input  logic [7:0]  wr_byte,
    output logic [7:0]  uart_tx_data_o,
    output logic        uart_tx_start_o,
    input  logic        uart_tx_busy_i,
    input  logic [7:0]  uart_rx_data_i,
    input  logic        uart_rx_valid_i,
    output logic [31:0] rd_data
);

    logic [7:0] rx_buf;
    logic       rx_full;
    logic       overrun;
    logic       tx_launch;

    assign tx_launch = wr_data_sel & ~uart_tx_busy_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_buf          <= 8'h00;
            rx_full         <= 1'b0;
            overrun         <= 1'b0;
            uart_tx_data_o  <= 8'h00;
            uart_tx_start_o <= 1'b0;
        end else begin
            uart_tx_start_o <= tx_launch;
            if (tx_launch)
                uart_tx_data_o <= wr_byte;

            // A byte arriving in the same cycle as a data read replaces the
            // one being read out, so the buffer stays full without overrun.
            if (uart_rx_valid_i) begin
                rx_buf  <= uart_rx_data_i;
                rx_full <= 1'b1;
            end else if (rd_data_sel) begin
                rx_full <= 1'b0;
            end

            // A fresh overrun event takes priority over a coincident clear.
            if (uart_rx_valid_i && rx_full && !rd_data_sel)
                overrun <= 1'b1;
            else if (rd_stat_sel)
                overrun <= 1'b0;
        end
    end

    always_comb begin
        rd_data = 32'h0;
        if (rd_data_sel) begin
            rd_data[7:0] = rx_buf;
        end else if (rd_stat_sel) begin
            rd_data[STAT_TX_READY] = ~uart_tx_busy_i;
            rd_data[STAT_RX_FULL]  = rx_full;
            rd_data[STAT_OVERRUN]  = overrun;
        end
    end

endmodule

// File: rtl/sram_uart_bridge.sv
// sram_uart_bridge: memory-side responder for the CPU data-memory request bus.
// Non-UART requests become a fixed two-cycle SRAM access (request cycle in
// IDLE, access cycle in RD/WR); two addresses map to the UART register file,
// which answers combinationally in the request cycle.
//   clk, rst                  clock, synchronous active-high reset
//   req_*                     active-low request bus from the MEM stage
//   rsp_data_o                read data back to the CPU
//   sram_*                    registered SRAM pins, sram_data_i is the bus input
//   uart_tx_* / uart_rx_*     UART PHY byte interface
//
// state   | meaning
// IDLE    | waiting for a request, UART accesses served here
// RD      | SRAM read access cycle, rsp_data_o follows sram_data_i
// WR      | SRAM write access cycle, data bus driven
module sram_uart_bridge
    import sram_uart_bridge_pkg::*;
#(
    parameter int          ADDR_W         = 20,
    parameter logic [31:0] UART_DATA_ADDR = DEF_UART_DATA_ADDR,
    parameter logic [31:0] UART_STAT_ADDR = DEF_UART_STAT_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_data_i,
    input  logic              req_we_n_i,
    input  logic              req_oe_n_i,
    input  logic              req_ce_n_i,
    input  logic [3:0]        req_be_n_i,
    output logic [31:0]       rsp_data_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_data_o,
    output logic              sram_data_oe_o,
    input  logic [31:0]       sram_data_i,
    output logic [3:0]        sram_be_n_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic [7:0]        uart_tx_data_o,
    output logic              uart_tx_start_o,
    input  logic              uart_tx_busy_i,
    input  logic [7:0]        uart_rx_data_i,
    input  logic              uart_rx_valid_i
);

    logic [1:0]  state;
    logic        req;
    logic        is_wr;
    logic        hit_data;
    logic        hit_stat;
    logic        in_idle;
    logic        sram_go;
    logic        uart_req;
    logic [31:0] uart_rd_data;

    assign req      = ~req_ce_n_i & (~req_oe_n_i | ~req_we_n_i);
    assign is_wr    = ~req_we_n_i;
    assign hit_data = (req_addr_i == UART_DATA_ADDR);
    assign hit_stat = (req_addr_i == UART_STAT_ADDR);
    assign in_idle  = (state == ST_IDLE);
    assign uart_req = in_idle & req & (hit_data | hit_stat);
    assign sram_go  = in_idle & req & ~(hit_data | hit_stat);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            sram_addr_o    <= '0;
            sram_data_o    <= 32'h0;
            sram_be_n_o    <= 4'hF;
            sram_ce_n_o    <= 1'b1;
            sram_oe_n_o    <= 1'b1;
            sram_we_n_o    <= 1'b1;
            sram_data_oe_o <= 1'b0;
        end else if (sram_go) begin
            state          <= is_wr ? ST_WR : ST_RD;
            sram_addr_o    <= req_addr_i[ADDR_W+1:2];
            sram_data_o    <= req_data_i;
            sram_be_n_o    <= req_be_n_i;
            sram_ce_n_o    <= 1'b0;
            sram_oe_n_o    <= is_wr;
            sram_we_n_o    <= ~is_wr;
            sram_data_oe_o <= is_wr;
        end else begin
            // RD/WR always fall back here; a new request in the following
            // IDLE cycle is accepted immediately.
            state          <= ST_IDLE;
            sram_ce_n_o    <= 1'b1;
            sram_oe_n_o    <= 1'b1;
            sram_we_n_o    <= 1'b1;
            sram_data_oe_o <= 1'b0;
        end
    end

    uart_mmio_regs u_regs (
        .clk             (clk),
        .rst             (rst),
        .rd_data_sel     (uart_req & ~is_wr & hit_data),
        .rd_stat_sel     (uart_req & ~is_wr & hit_stat),
        .wr_data_sel     (uart_req & is_wr & hit_data),
        .wr_byte         (req_data_i[7:0]),
        .uart_tx_data_o  (uart_tx_data_o),
        .uart_tx_start_o (uart_tx_start_o),
        .uart_tx_busy_i  (uart_tx_busy_i),
        .uart_rx_data_i  (uart_rx_data_i),
        .uart_rx_valid_i (uart_rx_valid_i),
        .rd_data         (uart_rd_data)
    );

    always_comb begin
        case (state)
            ST_RD:   rsp_data_o = sram_data_i;
            ST_WR:   rsp_data_o = 32'h0;
            default: rsp_data_o = uart_rd_data;
        endcase
    end

endmodule
